uart_rx: RTL and testbench

//  UART receiver, downstream of the UART transmitter: consumes the serial line it drives.

---
 rtl/uart_rx.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver for 8-bit frames: 1 start bit (0), 8 data bits LSB first,
// 1 parity bit (odd or even), and 1 or 2 stop bits (1). Each recovered byte
// is placed in a holding register and flagged with rx_valid. The byte stays
// there until the consumer acknowledges it or the next frame overwrites it.
//
// Ports
//   clk          system clock, single clock domain
//   rst          synchronous, active-high reset
//   Rx_in        asynchronous serial line, idle high
//   Two_stop     1 = frame has 2 stop bits (latched at start confirmation)
//   Odd_parity   1 = odd parity, 0 = even (latched at start confirmation)
//   rx_ack       consumer accepts rx_data; clears rx_valid
//   rx_data      last received byte, held until the next frame completes
//   rx_valid     1 = rx_data holds a byte that has not been read yet
//   parity_err   parity status of the byte in rx_data (1 = mismatch)
//   frame_err    1 = a stop bit of the byte in rx_data was sampled low
//   overrun_err  sticky: a frame completed while rx_valid was 1
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_DIVISOR = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_in,
  input  logic       Two_stop,
  input  logic       Odd_parity,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  // Terminal counts of the baud counter. The counter starts at 0 on state
  // entry, so a terminal count of N-1 samples N clocks after entry.
  localparam logic [13:0] FULL_TC = 14'(BAUD_DIVISOR - 1);
  localparam logic [13:0] HALF_TC = 14'((BAUD_DIVISOR / 2) - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t      state_r;
  logic [13:0] cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        two_stop_r;
  logic        odd_r;
  logic        par_err_r;
  logic        frame_r;
  logic        rx_meta_r;
  logic        rx_s;
  logic        baud_tc_s;

  // Even-parity reduction of one byte: 1 when the byte holds an odd number of ones.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= Rx_in;
      rx_s      <= rx_meta_r;
    end
  end

  // Sample strobe: half a bit into START, then one full bit period per later state.
  always_comb begin
    baud_tc_s = 1'b0;
    case (state_r)
      ST_START:                               baud_tc_s = (cnt_r == HALF_TC);
      ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: baud_tc_s = (cnt_r == FULL_TC);
      default:                                baud_tc_s = 1'b0;
    endcase
  end

  // Receive FSM with the baud counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 14'd0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      two_stop_r  <= 1'b0;
      odd_r       <= 1'b0;
      par_err_r   <= 1'b0;
      frame_r     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // DONE below overrides this, so a new byte wins over a coincident ack.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end

      case (state_r)
        ST_IDLE: begin
          cnt_r <= 14'd0;
          if (!rx_s) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_START: begin
          if (baud_tc_s) begin
            cnt_r <= 14'd0;
            if (!rx_s) begin
              // Start bit confirmed: freeze frame options for this frame.
              two_stop_r <= Two_stop;
              odd_r      <= Odd_parity;
              bit_cnt_r  <= 3'd0;
              frame_r    <= 1'b0;
              state_r    <= ST_DATA;
            end else begin
              // Line went high again before mid-bit: glitch, no flags.
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end

        ST_DATA: begin
          if (baud_tc_s) begin
            cnt_r     <= 14'd0;
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end

        ST_PARITY: begin
          if (baud_tc_s) begin
            cnt_r     <= 14'd0;
            // Total ones over data+parity must be odd in odd mode, even in even mode.
            par_err_r <= ((parity8(shift_r) ^ rx_s) != odd_r);
            state_r   <= ST_STOP1;
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end

        ST_STOP1: begin
          if (baud_tc_s) begin
            cnt_r   <= 14'd0;
            frame_r <= frame_r | ~rx_s;
            if (two_stop_r) begin
              state_r <= ST_STOP2;
            end else begin
              state_r <= ST_DONE;
            end
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end

        ST_STOP2: begin
          if (baud_tc_s) begin
            cnt_r   <= 14'd0;
            frame_r <= frame_r | ~rx_s;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end

        ST_DONE: begin
          cnt_r      <= 14'd0;
          rx_data    <= shift_r;
          parity_err <= par_err_r;
          frame_err  <= frame_r;
          rx_valid   <= 1'b1;
          // An ack in this same clock consumes the old byte, so nothing is lost.
          if (rx_valid && !rx_ack) begin
            overrun_err <= 1'b1;
          end else begin
            overrun_err <= overrun_err;
          end
          state_r <= ST_IDLE;
        end

        default: begin
          cnt_r   <= 14'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BAUD = 16;

  logic       clk;
  logic       rst;
  logic       Rx_in;
  logic       Two_stop;
  logic       Odd_parity;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_fails  = 0;

  uart_rx #(.BAUD_DIVISOR(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rx_in       (Rx_in),
    .Two_stop    (Two_stop),
    .Odd_parity  (Odd_parity),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its end within the time limit");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [7:0] data;
    logic       two;
    logic       odd;
    logic       p;
    logic       s1;
    logic       s2;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All line changes happen on the falling edge; each bit lasts BAUD clocks.
  task automatic drive_bit(input logic b);
    Rx_in = b;
    repeat (BAUD) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, parity bit.
  task automatic drive_prefix(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input logic two);
    drive_prefix(d, p);
    drive_bit(s1);
    if (two) drive_bit(s2);
    Rx_in = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    Rx_in      = 1'b1;
    Two_stop   = 1'b0;
    Odd_parity = 1'b0;
    rx_ack     = 1'b0;

    //            data   two   odd   p     s1    s2    perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun_err", 32'(overrun_err), 32'h0);

    // Table of frames, each acknowledged after checking
    for (int v = 0; v < 7; v++) begin
      Two_stop   = vecs[v].two;
      Odd_parity = vecs[v].odd;
      send_frame(vecs[v].data, vecs[v].p, vecs[v].s1, vecs[v].s2, vecs[v].two);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].data));
      check($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'h1);
      check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d overrun_err", v), 32'(overrun_err), 32'h0);
      pulse_ack();
      check($sformatf("vec%0d ack clears valid", v), 32'(rx_valid), 32'h0);
    end

    // Latency: rx_valid rises exactly 1 clk after the stop-bit sample
    Two_stop   = 1'b0;
    Odd_parity = 1'b1;
    drive_prefix(8'hA5, 1'b1);
    Rx_in = 1'b1;
    repeat (11) @(negedge clk);
    check("latency valid low at DONE", 32'(rx_valid), 32'h0);
    @(negedge clk);
    check("latency valid high after DONE", 32'(rx_valid), 32'h1);
    check("latency rx_data", 32'(rx_data), 32'hA5);
    repeat (6) @(negedge clk);
    pulse_ack();

    // Glitch: 5 clks low then high
    Rx_in = 1'b0;
    repeat (5) @(negedge clk);
    Rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch rx_valid", 32'(rx_valid), 32'h0);
    check("glitch parity_err", 32'(parity_err), 32'h0);
    check("glitch frame_err", 32'(frame_err), 32'h0);
    check("glitch rx_data held", 32'(rx_data), 32'hA5);

    // Back-to-back without ack
    Two_stop   = 1'b0;
    Odd_parity = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b first data", 32'(rx_data), 32'h01);
    check("b2b first overrun", 32'(overrun_err), 32'h0);
    send_frame(8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b second data", 32'(rx_data), 32'hFE);
    check("b2b valid", 32'(rx_valid), 32'h1);
    check("b2b overrun set", 32'(overrun_err), 32'h1);
    pulse_ack();
    check("b2b ack clears valid", 32'(rx_valid), 32'h0);
    check("b2b overrun sticky", 32'(overrun_err), 32'h1);
    pulse_ack();
    check("ack with valid=0 ignored", 32'(rx_valid), 32'h0);

    // Mid-frame reset during data bit 4, with an unread byte pending
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pre-rst valid", 32'(rx_valid), 32'h1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    Rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst rx_data", 32'(rx_data), 32'h00);
    check("midrst rx_valid", 32'(rx_valid), 32'h0);
    check("midrst parity_err", 32'(parity_err), 32'h0);
    check("midrst frame_err", 32'(frame_err), 32'h0);
    check("midrst overrun_err", 32'(overrun_err), 32'h0);
    Rx_in = 1'b1;
    repeat (200) @(negedge clk);
    check("midrst partial discarded", 32'(rx_valid), 32'h0);
    Two_stop   = 1'b0;
    Odd_parity = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    check("after rst data", 32'(rx_data), 32'h5A);
    check("after rst valid", 32'(rx_valid), 32'h1);
    check("after rst parity_err", 32'(parity_err), 32'h0);
    check("after rst frame_err", 32'(frame_err), 32'h0);
    pulse_ack();

    // rx_ack coincident with DONE while an older byte is unread
    Odd_parity = 1'b1;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    check("coinc pre valid", 32'(rx_valid), 32'h1);
    Odd_parity = 1'b0;
    drive_prefix(8'h77, 1'b0);
    Rx_in = 1'b1;
    repeat (11) @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("coinc valid", 32'(rx_valid), 32'h1);
    check("coinc data", 32'(rx_data), 32'h77);
    check("coinc overrun", 32'(overrun_err), 32'h0);
    check("coinc parity_err", 32'(parity_err), 32'h0);
    repeat (4) @(negedge clk);
    pulse_ack();
    check("coinc final ack", 32'(rx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
